// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry
// used by uart_rx, uart_tx and baud_gen.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous bit. The reset value is a
// parameter so an idle-high serial line does not look like a start bit.
module sync_2ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= {STAGES{RESET_VAL}};
    end else begin
      sync_chain <= {sync_chain[STAGES-2:0], d};
    end
  end

  assign q = sync_chain[STAGES-1];

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit data sampling, stop-bit
// check, and a valid/ready output holding one byte with overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 deliver;

  sync_2ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bitidx      <= '0;
      shreg       <= '0;
      deliver     <= 1'b0;
      data_out    <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      deliver     <= 1'b0;

      // A completed byte is loaded one clock after its stop bit; a held,
      // unaccepted byte wins and the new one is dropped.
      if (deliver) begin
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          data_out <= shreg;
          valid    <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (tick_16x) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end

          START: begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              if (!rx_s) begin
                state  <= DATA;
                bitidx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == CNT_END) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bitidx == BIT_LAST) begin
                bitidx <= '0;
                state  <= STOP;
              end else begin
                bitidx <= bitidx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STOP: begin
            if (cnt == CNT_END) begin
              cnt <= '0;
              if (rx_s) begin
                deliver <= 1'b1;
                state   <= IDLE;
              end else begin
                framing_err <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          BREAK: begin
            // Wait for the line to return high so a held-low line cannot
            // masquerade as a stream of start bits.
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are serialised from tick_16x counts
// and received bytes/pulses are compared against expected frame outcomes.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_16x;
  logic       rx;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       framing_err;
  logic       overrun;

  logic [1:0] tick_cnt = 2'd0;

  int checks   = 0;
  int failures = 0;

  // Observations collected by the monitor (single writer).
  int         err_cnt  = 0;
  int         ovr_cnt  = 0;
  int         hold_bad = 0;
  logic [7:0] got[$];
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .tick_16x   (tick_16x),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks: a bit period is 64 clocks.
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign tick_16x = (tick_cnt == 2'd3);

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs && (!valid || data_out !== prev_data)) hold_bad++;
      if (framing_err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (valid && ready) got.push_back(data_out);
      prev_valid = valid;
      prev_hs    = valid && ready;
      prev_data  = data_out;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick_16x !== 1'b1) @(posedge clk);
    end
  endtask

  // Sends start, 8 data bits LSB first, then the given stop level. With
  // coincide set, ready is raised for exactly the clock on which the byte is
  // loaded (one clock after the receiver's stop-bit sample, 9 ticks in).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit coincide);
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      wait_ticks(16);
    end
    #1 rx = stop_bit;
    if (coincide) begin
      wait_ticks(9);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      wait_ticks(7);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data_out); end
    if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", framing_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(20);
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    int gb = got.size();
    int eb = err_cnt;
    int ob = ovr_cnt;
    logic [7:0] exp_b[2];
    exp_b[0] = 8'h55;
    exp_b[1] = 8'hA3;
    ready = 1'b1;
    send_frame(exp_b[0], 1'b1, 1'b0);
    send_frame(exp_b[1], 1'b1, 1'b0);
    wait_ticks(16);
    @(negedge clk);
    checks += 3;
    if (got.size() - gb !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", got.size() - gb); end
    if (err_cnt - eb !== 0) begin failures++; $display("FAIL b2b_ferr: got %0d expected 0", err_cnt - eb); end
    if (ovr_cnt - ob !== 0) begin failures++; $display("FAIL b2b_ovr: got %0d expected 0", ovr_cnt - ob); end
    for (int i = 0; i < 2; i++) begin
      if (got.size() > gb + i) begin
        checks++;
        if (got[gb+i] !== exp_b[i]) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, got[gb+i], exp_b[i]); end
      end
    end
    $display("test_back_to_back done: 55 A3");
  endtask

  task automatic test_glitch();
    int gb = got.size();
    int eb = err_cnt;
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rx = 1'b1;
    wait_ticks(40);
    @(negedge clk);
    checks += 3;
    if (got.size() - gb !== 0) begin failures++; $display("FAIL glitch_valid: got %0d bytes expected 0", got.size() - gb); end
    if (valid !== 1'b0) begin failures++; $display("FAIL glitch_vlevel: got %b expected 0", valid); end
    if (err_cnt - eb !== 0) begin failures++; $display("FAIL glitch_ferr: got %0d expected 0", err_cnt - eb); end
    $display("test_glitch done");
  endtask

  task automatic test_framing();
    int gb = got.size();
    int eb = err_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(48);
    @(negedge clk);
    checks += 2;
    if (err_cnt - eb !== 1) begin failures++; $display("FAIL ferr_pulse: got %0d cycles expected 1", err_cnt - eb); end
    if (got.size() - gb !== 0) begin failures++; $display("FAIL ferr_nodata: got %0d bytes expected 0", got.size() - gb); end
    #1 rx = 1'b1;
    wait_ticks(32);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_ticks(16);
    @(negedge clk);
    checks += 2;
    if (got.size() - gb !== 1) begin failures++; $display("FAIL ferr_recover_cnt: got %0d expected 1", got.size() - gb); end
    else if (got[gb] !== 8'h81) begin failures++; $display("FAIL ferr_recover: got %h expected 81", got[gb]); end
    if (err_cnt - eb !== 1) begin failures++; $display("FAIL ferr_total: got %0d expected 1", err_cnt - eb); end
    $display("test_framing done");
  endtask

  task automatic test_overrun();
    int gb = got.size();
    int ob = ovr_cnt;
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_ticks(4);
    @(negedge clk);
    checks += 4;
    if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b expected 1", valid); end
    if (data_out !== 8'h11) begin failures++; $display("FAIL ovr_data: got %h expected 11", data_out); end
    if (ovr_cnt - ob !== 1) begin failures++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt - ob); end
    if (got.size() - gb !== 0) begin failures++; $display("FAIL ovr_early: got %0d bytes expected 0", got.size() - gb); end
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    checks += 2;
    if (valid !== 1'b0) begin failures++; $display("FAIL ovr_drop: got valid %b expected 0", valid); end
    if (got.size() - gb !== 1 || got[gb] !== 8'h11) begin
      failures++;
      $display("FAIL ovr_accept: got %0d bytes first %h expected 1 byte 11", got.size() - gb, (got.size() > gb) ? got[gb] : 8'hxx);
    end
    $display("test_overrun done");
  endtask

  task automatic test_coincide();
    int gb = got.size();
    int ob = ovr_cnt;
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    @(negedge clk);
    checks += 4;
    if (valid !== 1'b1) begin failures++; $display("FAIL coin_valid: got %b expected 1", valid); end
    if (data_out !== 8'h22) begin failures++; $display("FAIL coin_data: got %h expected 22", data_out); end
    if (ovr_cnt - ob !== 0) begin failures++; $display("FAIL coin_ovr: got %0d expected 0", ovr_cnt - ob); end
    if (got.size() - gb !== 1 || got[gb] !== 8'h11) begin
      failures++;
      $display("FAIL coin_first: got %0d bytes expected 1 byte 11", got.size() - gb);
    end
    @(posedge clk);
    #1 ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (got.size() - gb !== 2 || got[gb+1] !== 8'h22) begin
      failures++;
      $display("FAIL coin_second: got %0d bytes expected 2 ending 22", got.size() - gb);
    end
    if (valid !== 1'b0) begin failures++; $display("FAIL coin_drain: got valid %b expected 0", valid); end
    $display("test_coincide done");
  endtask

  task automatic test_reset_midframe();
    int gb = got.size();
    int eb = err_cnt;
    logic [7:0] b = 8'hF0;
    ready = 1'b1;
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      #1 rx = b[i];
      wait_ticks(16);
    end
    #1 rx = b[4];
    wait_ticks(8);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", valid); end
    if (data_out !== 8'h00) begin failures++; $display("FAIL mid_data: got %h expected 00", data_out); end
    if (framing_err !== 1'b0) begin failures++; $display("FAIL mid_ferr: got %b expected 0", framing_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL mid_ovr: got %b expected 0", overrun); end
    rx = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(32);
    send_frame(8'h0F, 1'b1, 1'b0);
    wait_ticks(16);
    @(negedge clk);
    checks += 2;
    if (got.size() - gb !== 1 || got[gb] !== 8'h0F) begin
      failures++;
      $display("FAIL mid_after: got %0d bytes expected 1 byte 0F", got.size() - gb);
    end
    if (err_cnt - eb !== 0) begin failures++; $display("FAIL mid_err: got %0d expected 0", err_cnt - eb); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_random();
    int gb = got.size();
    int eb = err_cnt;
    int ob = ovr_cnt;
    int exp_err = 0;
    logic [7:0] exp_q[$];
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic [7:0] b;
          bit bad;
          b   = 8'($urandom);
          bad = ($urandom_range(0, 3) == 0);
          send_frame(b, !bad, 1'b0);
          if (bad) begin
            exp_err++;
            wait_ticks(16 * $urandom_range(1, 2));
            #1 rx = 1'b1;
            wait_ticks(16);
          end else begin
            exp_q.push_back(b);
          end
          $display("random frame %0d: byte %h stop_ok %0d", k, b, !bad);
          wait_ticks(16 * $urandom_range(0, 2));
        end
        wait_ticks(32);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (got.size() - gb !== exp_q.size()) begin failures++; $display("FAIL rnd_count: got %0d expected %0d", got.size() - gb, exp_q.size()); end
    if (err_cnt - eb !== exp_err) begin failures++; $display("FAIL rnd_ferr: got %0d expected %0d", err_cnt - eb, exp_err); end
    if (ovr_cnt - ob !== 0) begin failures++; $display("FAIL rnd_ovr: got %0d expected 0", ovr_cnt - ob); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got.size() > gb + i) begin
        checks++;
        if (got[gb+i] !== exp_q[i]) begin failures++; $display("FAIL rnd_data%0d: got %h expected %h", i, got[gb+i], exp_q[i]); end
      end
    end
    $display("test_random done: %0d bytes %0d framing errors", exp_q.size(), exp_err);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_coincide();
    test_reset_midframe();
    test_random();
    checks++;
    if (hold_bad !== 0) begin failures++; $display("FAIL hold_stable: got %0d violations expected 0", hold_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
